// File: rtl/cd_pkg.sv
// rtl/cd_pkg.sv - shared CDBUS receive definitions
package cd_pkg;

  // One-hot receive state encoding
  typedef enum logic [4:0] {
    WAIT_IDLE = 5'b00001,
    IDLE      = 5'b00010,
    HDR       = 5'b00100,
    PAYLOAD   = 5'b01000,
    CRC       = 5'b10000
  } rx_state_t;

  localparam logic [7:0]  CD_BCAST       = 8'hFF;
  localparam logic [15:0] CD_CRC_RESIDUE = 16'h0000;
  localparam logic [7:0]  CD_HDR_LEN     = 8'd3;

endpackage

// File: rtl/rx_frame.sv
// rtl/rx_frame.sv - CDBUS receive frame assembler into an RX page buffer
module rx_frame
  import cd_pkg::*;
#(
  parameter int MAX_LEN = 253
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        promisc,
  input  logic [7:0]  filter,
  input  logic [7:0]  filter_m0,
  input  logic [7:0]  filter_m1,
  input  logic        bus_idle,
  input  logic        rx_break,
  input  logic [7:0]  data,
  input  logic        data_clk,
  input  logic [15:0] crc_data,
  input  logic        buf_avail,
  output logic [7:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        wr_en,
  output logic        frame_done,
  output logic [7:0]  frame_len,
  output logic        rx_lost,
  output logic        rx_err,
  output logic        break_det
);

  localparam logic [8:0] MAX_LEN_W = 9'(MAX_LEN);

  rx_state_t  state, state_nxt;
  logic [7:0] idx, idx_nxt;
  logic [7:0] len_r, len_nxt;
  logic       keep, keep_nxt;
  logic       crc_second, crc_second_nxt;
  logic [7:0] wr_addr_nxt, wr_data_nxt, frame_len_nxt;
  logic       wr_en_nxt, frame_done_nxt, rx_lost_nxt, rx_err_nxt;
  logic       dst_match, in_frame;

  assign dst_match = promisc | (data == filter) | (data == CD_BCAST) |
                     (data == filter_m0) | (data == filter_m1);
  assign in_frame  = (state == HDR) | (state == PAYLOAD) | (state == CRC);

  // Next-state and registered-output decode; break outranks truncation, which outranks bytes
  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    len_nxt        = len_r;
    keep_nxt       = keep;
    crc_second_nxt = crc_second;
    wr_en_nxt      = 1'b0;
    wr_addr_nxt    = wr_addr;
    wr_data_nxt    = wr_data;
    frame_done_nxt = 1'b0;
    frame_len_nxt  = frame_len;
    rx_lost_nxt    = 1'b0;
    rx_err_nxt     = 1'b0;
    if (rx_break) begin
      if (in_frame) state_nxt = WAIT_IDLE;
    end else if (in_frame && bus_idle) begin
      rx_err_nxt = 1'b1;
      state_nxt  = IDLE;
    end else begin
      case (state)
        WAIT_IDLE: if (bus_idle) state_nxt = IDLE;
        IDLE: if (data_clk) begin
          keep_nxt       = buf_avail;
          wr_en_nxt      = buf_avail;
          wr_addr_nxt    = 8'd0;
          wr_data_nxt    = data;
          idx_nxt        = 8'd1;
          crc_second_nxt = 1'b0;
          state_nxt      = HDR;
        end
        HDR: if (data_clk) begin
          if (idx == 8'd1) begin
            if (!dst_match) begin
              state_nxt = WAIT_IDLE;
            end else if (!keep) begin
              rx_lost_nxt = 1'b1;
              state_nxt   = WAIT_IDLE;
            end else begin
              wr_en_nxt   = 1'b1;
              wr_addr_nxt = idx;
              wr_data_nxt = data;
              idx_nxt     = 8'd2;
            end
          end else if ({1'b0, data} > MAX_LEN_W) begin
            rx_err_nxt = 1'b1;
            state_nxt  = WAIT_IDLE;
          end else begin
            wr_en_nxt   = keep;
            wr_addr_nxt = idx;
            wr_data_nxt = data;
            len_nxt     = data;
            idx_nxt     = 8'd3;
            state_nxt   = (data == 8'd0) ? CRC : PAYLOAD;
          end
        end
        PAYLOAD: if (data_clk) begin
          wr_en_nxt   = keep;
          wr_addr_nxt = idx;
          wr_data_nxt = data;
          idx_nxt     = idx + 8'd1;
          if (idx == len_r + 8'd2) state_nxt = CRC;
        end
        CRC: if (data_clk) begin
          if (!crc_second) begin
            crc_second_nxt = 1'b1;
          end else begin
            if (crc_data == CD_CRC_RESIDUE) begin
              frame_done_nxt = 1'b1;
              frame_len_nxt  = CD_HDR_LEN + len_r;
            end else begin
              rx_err_nxt = 1'b1;
            end
            state_nxt = WAIT_IDLE;
          end
        end
        default: state_nxt = WAIT_IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= WAIT_IDLE;
      idx        <= 8'd0;
      len_r      <= 8'd0;
      keep       <= 1'b0;
      crc_second <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= 8'd0;
      wr_data    <= 8'd0;
      frame_done <= 1'b0;
      frame_len  <= 8'd0;
      rx_lost    <= 1'b0;
      rx_err     <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      len_r      <= len_nxt;
      keep       <= keep_nxt;
      crc_second <= crc_second_nxt;
      wr_en      <= wr_en_nxt;
      wr_addr    <= wr_addr_nxt;
      wr_data    <= wr_data_nxt;
      frame_done <= frame_done_nxt;
      frame_len  <= frame_len_nxt;
      rx_lost    <= rx_lost_nxt;
      rx_err     <= rx_err_nxt;
      break_det  <= rx_break;
    end
  end

endmodule

// File: tb/tb_rx_frame.sv
// tb/tb_rx_frame.sv - self-checking bench for rx_frame
module tb_rx_frame;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        promisc;
  logic [7:0]  filter, filter_m0, filter_m1;
  logic        bus_idle, rx_break;
  logic [7:0]  data;
  logic        data_clk;
  logic [15:0] crc_data;
  logic        buf_avail;
  logic [7:0]  wr_addr, wr_data, frame_len;
  logic        wr_en, frame_done, rx_lost, rx_err, break_det;

  rx_frame #(.MAX_LEN(253)) dut (
    .clk(clk), .reset_n(reset_n), .promisc(promisc), .filter(filter),
    .filter_m0(filter_m0), .filter_m1(filter_m1), .bus_idle(bus_idle),
    .rx_break(rx_break), .data(data), .data_clk(data_clk), .crc_data(crc_data),
    .buf_avail(buf_avail), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
    .frame_done(frame_done), .frame_len(frame_len), .rx_lost(rx_lost),
    .rx_err(rx_err), .break_det(break_det)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        promisc;
    logic [7:0]  filter, m0, m1;
    logic        buf_avail;
    logic [7:0]  src, dst, len;
    logic [31:0] pl;
    logic [7:0]  crc_xor;
    logic [15:0] nsend;
    logic [15:0] exp_nwr;
    logic        exp_done, exp_err, exp_lost;
    logic [7:0]  exp_flen;
  } vec_t;

  vec_t       vecs [10];
  logic [7:0] fr [300];
  int         fr_n;
  logic [15:0] crc_run;
  int n_checks = 0;
  int n_errors = 0;

  // Free-running observation of DUT outputs, sampled on the falling edge
  logic [7:0] log_a [1024];
  logic [7:0] log_d [1024];
  int wr_total = 0, n_done = 0, n_err = 0, n_lost = 0, n_brk = 0;
  logic [7:0] last_flen = 8'd0;
  always @(negedge clk) begin
    if (wr_en && wr_total < 1024) begin
      log_a[wr_total] = wr_addr;
      log_d[wr_total] = wr_data;
      wr_total++;
    end
    if (frame_done) begin n_done++; last_flen = frame_len; end
    if (rx_err) n_err++;
    if (rx_lost) n_lost++;
    if (break_det) n_brk++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    data     = b;
    crc_run  = crc_upd(crc_run, b);
    crc_data = crc_run;
    data_clk = 1'b1;
    cyc();
    data_clk = 1'b0;
    cyc();
  endtask

  // Build the full on-wire frame for a vector, CRC-16/MODBUS appended low byte first
  task automatic build_frame(input vec_t v);
    logic [15:0] c;
    logic [31:0] pl;
    pl = v.pl;
    fr[0] = v.src;
    fr[1] = v.dst;
    fr[2] = v.len;
    for (int i = 0; i < int'(v.len) && i < 290; i++)
      fr[3+i] = (i < 4) ? pl[8*i +: 8] : 8'(i);
    c = 16'hFFFF;
    for (int i = 0; i < 3 + int'(v.len) && i < 293; i++) c = crc_upd(c, fr[i]);
    if (3 + int'(v.len) + 1 < 300) begin
      fr[3+v.len] = c[7:0] ^ v.crc_xor;
      fr[4+v.len] = c[15:8];
    end
    fr_n = (v.nsend != 0) ? int'(v.nsend) : 5 + int'(v.len);
  endtask

  task automatic frame_start(input vec_t v);
    promisc   = v.promisc;
    filter    = v.filter;
    filter_m0 = v.m0;
    filter_m1 = v.m1;
    buf_avail = v.buf_avail;
    bus_idle  = 1'b1;
    crc_data  = 16'hFFFF;
    repeat (3) cyc();
    bus_idle  = 1'b0;
    crc_run   = 16'hFFFF;
    cyc();
  endtask

  task automatic frame_end();
    bus_idle = 1'b1;
    crc_data = 16'hFFFF;
    repeat (4) cyc();
  endtask

  task automatic run_vector(input int k);
    int w0, d0, e0, l0, nw;
    vec_t v;
    v = vecs[k];
    build_frame(v);
    w0 = wr_total; d0 = n_done; e0 = n_err; l0 = n_lost;
    frame_start(v);
    for (int i = 0; i < fr_n; i++) send_byte(fr[i]);
    frame_end();
    nw = wr_total - w0;
    check($sformatf("v%0d wr_count", k), nw, v.exp_nwr);
    for (int i = 0; i < nw && i < int'(v.exp_nwr); i++) begin
      check($sformatf("v%0d wr%0d_addr", k, i), log_a[w0+i], i);
      check($sformatf("v%0d wr%0d_data", k, i), log_d[w0+i], fr[i]);
    end
    check($sformatf("v%0d frame_done", k), n_done - d0, v.exp_done);
    check($sformatf("v%0d rx_err", k), n_err - e0, v.exp_err);
    check($sformatf("v%0d rx_lost", k), n_lost - l0, v.exp_lost);
    if (v.exp_done) check($sformatf("v%0d frame_len", k), last_flen, v.exp_flen);
  endtask

  initial begin
    int w0, d0, e0, b0;
    //         prm filt  m0     m1     ba  src    dst    len    payload       xor    ns  nwr d e l flen
    vecs[0] = {1'b0, 8'h05, 8'h10, 8'h10, 1'b1, 8'h01, 8'h05, 8'd2, 32'h0000_55AA, 8'h00, 16'd0, 16'd5, 1'b1, 1'b0, 1'b0, 8'd5};
    vecs[1] = {1'b0, 8'h05, 8'h10, 8'h10, 1'b1, 8'h01, 8'h05, 8'd2, 32'h0000_55AA, 8'h01, 16'd0, 16'd5, 1'b0, 1'b1, 1'b0, 8'd0};
    vecs[2] = {1'b0, 8'h05, 8'h10, 8'h10, 1'b1, 8'h01, 8'h07, 8'd2, 32'h0000_55AA, 8'h00, 16'd0, 16'd1, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[3] = {1'b0, 8'h05, 8'h10, 8'h10, 1'b1, 8'h02, 8'hFF, 8'd2, 32'h0000_1234, 8'h00, 16'd0, 16'd5, 1'b1, 1'b0, 1'b0, 8'd5};
    vecs[4] = {1'b0, 8'h05, 8'h10, 8'h10, 1'b1, 8'h03, 8'h10, 8'd1, 32'h0000_003C, 8'h00, 16'd0, 16'd4, 1'b1, 1'b0, 1'b0, 8'd4};
    vecs[5] = {1'b1, 8'h05, 8'h10, 8'h10, 1'b1, 8'h04, 8'h33, 8'd0, 32'h0000_0000, 8'h00, 16'd0, 16'd3, 1'b1, 1'b0, 1'b0, 8'd3};
    vecs[6] = {1'b0, 8'h05, 8'h10, 8'h10, 1'b0, 8'h01, 8'h05, 8'd2, 32'h0000_55AA, 8'h00, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 8'd0};
    vecs[7] = {1'b0, 8'h05, 8'h10, 8'h10, 1'b1, 8'h01, 8'h05, 8'hFE, 32'h0000_0000, 8'h00, 16'd3, 16'd2, 1'b0, 1'b1, 1'b0, 8'd0};
    vecs[8] = {1'b0, 8'h05, 8'h10, 8'h10, 1'b1, 8'h01, 8'h05, 8'd4, 32'h4433_2211, 8'h00, 16'd5, 16'd5, 1'b0, 1'b1, 1'b0, 8'd0};
    vecs[9] = {1'b0, 8'h05, 8'h10, 8'h20, 1'b1, 8'h09, 8'h20, 8'd3, 32'h00CC_BBAA, 8'h00, 16'd0, 16'd6, 1'b1, 1'b0, 1'b0, 8'd6};

    reset_n = 1'b0; promisc = 1'b0; filter = 8'h05; filter_m0 = 8'h10; filter_m1 = 8'h10;
    bus_idle = 1'b0; rx_break = 1'b0; data = 8'h00; data_clk = 1'b0;
    crc_data = 16'hFFFF; buf_avail = 1'b1; crc_run = 16'hFFFF;
    repeat (3) cyc();
    check("reset_outputs", {wr_en, wr_addr, wr_data, frame_done, frame_len, rx_lost, rx_err, break_det}, 32'd0);
    reset_n = 1'b1;
    cyc();

    // WAIT_IDLE must ignore bytes until the bus has been seen idle
    w0 = wr_total;
    send_byte(8'h01);
    check("wait_idle_ignores", wr_total - w0, 0);

    for (int k = 0; k < 10; k++) run_vector(k);

    // Break in the middle of a payload: one break_det, no completion, no error
    build_frame(vecs[8]);
    w0 = wr_total; d0 = n_done; e0 = n_err; b0 = n_brk;
    frame_start(vecs[8]);
    for (int i = 0; i < 4; i++) send_byte(fr[i]);
    rx_break = 1'b1;
    cyc();
    rx_break = 1'b0;
    check("break_det_pulse", break_det, 1);
    cyc();
    check("break_det_width", break_det, 0);
    for (int i = 4; i < 9; i++) send_byte(fr[i]);
    frame_end();
    check("break_writes", wr_total - w0, 4);
    check("break_no_done", n_done - d0, 0);
    check("break_no_err", n_err - e0, 0);
    check("break_count", n_brk - b0, 1);

    // Asynchronous reset while a write strobe is active
    build_frame(vecs[0]);
    frame_start(vecs[0]);
    send_byte(fr[0]);
    data = fr[1];
    data_clk = 1'b1;
    cyc();
    check("wr_en_before_reset", wr_en, 1);
    reset_n = 1'b0;
    #1;
    check("midframe_reset_outputs", {wr_en, wr_addr, wr_data, frame_done, frame_len, rx_lost, rx_err, break_det}, 32'd0);
    data_clk = 1'b0;
    cyc();
    reset_n = 1'b1;
    frame_end();
    run_vector(0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rx_frame.md
# rx_frame

Receive-side frame assembler. It sits directly downstream of the RX deserializer and consumes its byte stream, bus-idle and break indications, and running CRC. It delimits CDBUS frames (src, dst, len, payload, crc_l, crc_h), applies destination filtering, writes header and payload into an RX page buffer, and reports frame completion or error to the buffer manager.

## Interface

Parameters:
- `MAX_LEN`, default 253: maximum payload length. Frames with a larger `len` byte are rejected.

Ports (all synchronous to `clk`):
- `clk` in 1: clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `promisc` in 1: accept any dst.
- `filter` in 8: unicast address.
- `filter_m0` in 8, `filter_m1` in 8: multicast addresses.
- `bus_idle` in 1: level from deserializer; high while the bus is idle.
- `rx_break` in 1: 1-cycle pulse from deserializer.
- `data` in 8: byte from deserializer; valid when `data_clk` is high.
- `data_clk` in 1: 1-cycle byte strobe.
- `crc_data` in 16: running CRC over all received bytes; cleared while the bus is idle.
- `buf_avail` in 1: a free page is available; level from the buffer manager.
- `wr_addr` out 8: byte index within the page.
- `wr_data` out 8: byte to write.
- `wr_en` out 1: write strobe.
- `frame_done` out 1: pulse; the page holds a valid frame.
- `frame_len` out 8: bytes stored, i.e. 3+len; valid with `frame_done`, held until the next `frame_done`.
- `rx_lost` out 1: pulse; a matching frame was dropped because no buffer was available.
- `rx_err` out 1: pulse; CRC mismatch, truncation or over-length.
- `break_det` out 1: pulse; registered copy of `rx_break`.

## Operation

States are WAIT_IDLE, IDLE, HDR, PAYLOAD, CRC.

- **Reset:** state=WAIT_IDLE. All outputs are 0: `wr_*`, `frame_len`, pulses.
- **WAIT_IDLE:** ignores `data_clk`. Goes to IDLE when `bus_idle`=1.
- **IDLE:** the first `data_clk` is byte0 (src).
  - Latch `keep = buf_avail`.
  - If `keep`=1, write byte0 at address 0.
  - Go to HDR with `idx`=1.
- **HDR**, byte1 (dst):
  - `match = promisc | dst==filter | dst==8'hFF | dst==filter_m0 | dst==filter_m1`.
  - No match: go to WAIT_IDLE silently, with no pulse.
  - Match with `keep`=0: pulse `rx_lost`, go to WAIT_IDLE.
  - Otherwise write byte1.
- **HDR**, byte2 (len):
  - If len>`MAX_LEN`: pulse `rx_err`, go to WAIT_IDLE.
  - Otherwise write byte2 and latch `len`.
  - Next state is PAYLOAD, or CRC directly if len=0.
- **PAYLOAD:** write each byte at `idx`, then `idx`+1. After len bytes, go to CRC.
- **CRC:** the two CRC bytes are not written. On the second CRC byte's `data_clk`:
  - If `crc_data`==16'h0000 (CRC-16/MODBUS residue including the CRC bytes): pulse `frame_done` and set `frame_len`=3+len.
  - Otherwise pulse `rx_err`.
  - Either way, go to WAIT_IDLE.
- **Abort conditions:**
  - `bus_idle`=1 in HDR, PAYLOAD or CRC (truncated frame): pulse `rx_err` and go to IDLE directly, since the bus is already idle.
  - `rx_break` in any state: `break_det` pulse. In HDR, PAYLOAD or CRC it also aborts with no `rx_err`, and the state goes to WAIT_IDLE.
- **Address width:** `idx` is 8 bits. The maximum stored index is 2+`MAX_LEN`=255, so there is no wrap-around.
- **Write gating:** no `wr_en` is issued when `keep`=0 or after a filter miss.
- **Simultaneous events:** `data_clk` and `rx_break` are never asserted together by the deserializer. If they are, `rx_break` wins.
- **Mid-frame `buf_avail` drop:** ignored once `keep` has been latched.

## Timing

- `wr_en`, `wr_addr` and `wr_data` are registered and appear exactly 1 cycle after the corresponding `data_clk`.
- `frame_done`, `rx_err` and `rx_lost` appear 1 cycle after the deciding `data_clk`, or 1 cycle after `bus_idle` rises for truncation.
- `break_det` appears 1 cycle after `rx_break`.
- All pulses are exactly 1 cycle wide. At most one of `frame_done`, `rx_err` or `rx_lost` is asserted per frame.
- The buffer manager must observe `frame_done` and switch pages before the next frame's byte0. The minimum gap is the idle time, which is at least 1 character time.

## Structure

- A shared package `cd_pkg` holds:
  - the state encoding, one-hot 5 bits;
  - `CD_BCAST` = 8'hFF;
  - `CD_CRC_RESIDUE` = 16'h0000;
  - `CD_HDR_LEN` = 3.
- Single module, no sub-modules. The filter compare is a local combinational expression.

## Test plan

- Unicast frame: `filter`=0x05; send src 0x01, dst 0x05, len 2, payload AA 55, valid CRC.
  - Writes: addr 0..4 = 01 05 02 AA 55.
  - Then `frame_done` with `frame_len`=5.
- Same frame with `crc_l` XOR 0x01:
  - Identical writes.
  - `rx_err` pulse, no `frame_done`.
- Filter miss: dst 0x07, `promisc`=0, m0=m1=0x10.
  - Exactly 1 `wr_en` (byte0), then none.
  - No pulses. The next idle-separated frame is still received.
- Filter variants:
  - dst 0xFF is accepted (broadcast).
  - dst 0x10 with m0=0x10 is accepted (multicast).
  - `promisc`=1 with dst 0x33 is accepted.
- No buffer: `buf_avail`=0 at byte0 with a matching dst.
  - Zero writes, `rx_lost` pulse.
- Errors:
  - len=0xFE: `rx_err` after byte2.
  - `bus_idle` rises after payload byte 1 of len 4: `rx_err`, and the next frame is accepted.
  - `rx_break` mid-payload: `break_det`, no `frame_done`.
  - `reset_n` low mid-frame: all outputs 0.
